// File: rtl/vx_tcu_uop_sequencer.sv
// Expands one WMMA instruction into per-step tensor-core micro-ops (m/n/k steps,
// A/B/C register indices, B sub-block select, first/last flags).
module vx_tcu_uop_sequencer #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_REGS    = 8,
  parameter int DP          = 0,
  parameter int TAG_W       = 16,
  localparam int NT       = NUM_THREADS,
  localparam int NR       = NUM_REGS,
  localparam int TILE_CAP = NT * NR,
  localparam int LC       = $clog2(TILE_CAP),
  localparam int EN       = LC / 2,
  localparam int EM       = LC - EN,
  localparam int TILE_M   = 1 << EM,
  localparam int TILE_N   = 1 << EN,
  localparam int TILE_K   = TILE_CAP / ((TILE_M > TILE_N) ? TILE_M : TILE_N),
  localparam int LT       = $clog2(NT),
  localparam int TEN      = LT / 2,
  localparam int TEM      = LT - TEN,
  localparam int TC_M     = 1 << TEM,
  localparam int TC_N     = 1 << TEN,
  localparam int TC_K     = (DP != 0) ? DP : NT / ((TC_M > TC_N) ? TC_M : TC_N),
  localparam int M_ST     = TILE_M / TC_M,
  localparam int N_ST     = TILE_N / TC_N,
  localparam int K_ST     = TILE_K / TC_K,
  localparam int A_SUB    = NT / (TC_M * TC_K),
  localparam int B_SUB    = NT / (TC_K * TC_N),
  localparam int NRB      = TILE_N * TILE_K / NT,
  localparam int RA       = 0,
  localparam int RB       = (NRB == 4) ? 28 : 10,
  localparam int RC       = (NRB == 4) ? 10 : 24,
  localparam int MW       = (M_ST > 1) ? $clog2(M_ST) : 1,
  localparam int NW       = (N_ST > 1) ? $clog2(N_ST) : 1,
  localparam int KW       = (K_ST > 1) ? $clog2(K_ST) : 1,
  localparam int BW       = (B_SUB > 1) ? $clog2(B_SUB) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [3:0]       in_fmt_s,
  input  logic [3:0]       in_fmt_d,
  input  logic             in_k_inner,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_fmt_s,
  output logic [3:0]       out_fmt_d,
  output logic [MW-1:0]    out_step_m,
  output logic [NW-1:0]    out_step_n,
  output logic [KW-1:0]    out_step_k,
  output logic [4:0]       out_ra,
  output logic [4:0]       out_rb,
  output logic [4:0]       out_rc,
  output logic [BW-1:0]    out_b_sel,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  // Geometry sanity: the register file only has 32 entries per operand window.
  if (NT < 4 || (NT & (NT - 1)) != 0) begin : g_bad_nt
    $error("NUM_THREADS must be a power of 2 and at least 4");
  end
  if ((NR & (NR - 1)) != 0) begin : g_bad_nr
    $error("NUM_REGS must be a power of 2");
  end
  if (A_SUB < 1 || B_SUB < 1 || K_ST < 1) begin : g_bad_geom
    $error("tile geometry does not divide evenly");
  end
  if (RA + ((M_ST - 1) * K_ST + K_ST - 1) / A_SUB > 31 ||
      RB + ((N_ST - 1) * K_ST + K_ST - 1) / B_SUB > 31 ||
      RC + (M_ST - 1) * N_ST + N_ST - 1 > 31) begin : g_bad_idx
    $error("register index exceeds 31");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic          k_inner_q;
  logic          hs, accept, m_max, n_max, k_max, load;
  logic [MW-1:0] nm;
  logic [NW-1:0] nn;
  logic [KW-1:0] nk;
  logic [4:0]    ra_n, rb_n, rc_n;
  logic [BW-1:0] bsel_n;
  logic          first_n, last_n;
  int            mi, ni, ki;

  assign hs       = out_valid && out_ready;
  assign in_ready = !flush && ((state == IDLE) || (hs && out_last));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign load     = accept || (hs && !out_last);

  assign m_max = (int'(out_step_m) == M_ST - 1);
  assign n_max = (int'(out_step_n) == N_ST - 1);
  assign k_max = (int'(out_step_k) == K_ST - 1);

  // Next step counters; the innermost loop is k or n depending on the instruction.
  always_comb begin
    nm = out_step_m;
    nn = out_step_n;
    nk = out_step_k;
    if (accept) begin
      nm = '0;
      nn = '0;
      nk = '0;
    end else if (k_inner_q) begin
      if (k_max) begin
        nk = '0;
        if (n_max) begin
          nn = '0;
          nm = out_step_m + MW'(1);
        end else begin
          nn = out_step_n + NW'(1);
        end
      end else begin
        nk = out_step_k + KW'(1);
      end
    end else begin
      if (n_max) begin
        nn = '0;
        if (k_max) begin
          nk = '0;
          nm = out_step_m + MW'(1);
        end else begin
          nk = out_step_k + KW'(1);
        end
      end else begin
        nn = out_step_n + NW'(1);
      end
    end
  end

  always_comb begin
    mi      = int'(nm);
    ni      = int'(nn);
    ki      = int'(nk);
    ra_n    = 5'(RA + (mi * K_ST + ki) / A_SUB);
    rb_n    = 5'(RB + (ni * K_ST + ki) / B_SUB);
    bsel_n  = BW'((ni * K_ST + ki) % B_SUB);
    rc_n    = 5'(RC + mi * N_ST + ni);
    first_n = (nk == '0);
    last_n  = (mi == M_ST - 1) && (ni == N_ST - 1) && (ki == K_ST - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k_inner_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_fmt_s  <= '0;
      out_fmt_d  <= '0;
      out_step_m <= '0;
      out_step_n <= '0;
      out_step_k <= '0;
      out_ra     <= '0;
      out_rb     <= '0;
      out_rc     <= '0;
      out_b_sel  <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_step_m <= '0;
      out_step_n <= '0;
      out_step_k <= '0;
    end else begin
      if (accept) begin
        state     <= RUN;
        out_valid <= 1'b1;
        out_tag   <= in_tag;
        out_fmt_s <= in_fmt_s;
        out_fmt_d <= in_fmt_d;
        k_inner_q <= in_k_inner;
      end else if (hs && out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
      if (load) begin
        out_step_m <= nm;
        out_step_n <= nn;
        out_step_k <= nk;
        out_ra     <= ra_n;
        out_rb     <= rb_n;
        out_rc     <= rc_n;
        out_b_sel  <= bsel_n;
        out_first  <= first_n;
        out_last   <= last_n;
      end
    end
  end

endmodule

// File: tb/tb_vx_tcu_uop_sequencer.sv
// Scoreboard bench: each accepted instruction queues its expected uop stream,
// which is compared against every out_valid/out_ready handshake.
module tb_vx_tcu_uop_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, in_ready, in_k_inner, flush, out_valid, out_ready;
  logic [15:0] in_tag, out_tag;
  logic [3:0]  in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
  logic [0:0]  out_step_m, out_b_sel;
  logic [1:0]  out_step_n, out_step_k;
  logic [4:0]  out_ra, out_rb, out_rc;
  logic        out_first, out_last, busy;

  logic        in_valid2, in_ready2, out_valid2;
  logic [15:0] out_tag2;
  logic [3:0]  out_fmt_s2, out_fmt_d2;
  logic [0:0]  out_step_m2, out_b_sel2;
  logic [1:0]  out_step_n2, out_step_k2;
  logic [4:0]  out_ra2, out_rb2, out_rc2;
  logic        out_first2, out_last2, busy2;

  vx_tcu_uop_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d), .in_k_inner(in_k_inner),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d), .out_step_m(out_step_m),
    .out_step_n(out_step_n), .out_step_k(out_step_k), .out_ra(out_ra), .out_rb(out_rb),
    .out_rc(out_rc), .out_b_sel(out_b_sel), .out_first(out_first), .out_last(out_last),
    .busy(busy)
  );

  // 32 threads: tile 16x16x16, block 8x4x4 -> M_ST=2, N_ST=4, K_ST=4, NRB=8.
  vx_tcu_uop_sequencer #(.NUM_THREADS(32), .NUM_REGS(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_tag(16'h3232), .in_fmt_s(4'd1), .in_fmt_d(4'd2), .in_k_inner(1'b1),
    .flush(1'b0), .out_valid(out_valid2), .out_ready(1'b1), .out_tag(out_tag2),
    .out_fmt_s(out_fmt_s2), .out_fmt_d(out_fmt_d2), .out_step_m(out_step_m2),
    .out_step_n(out_step_n2), .out_step_k(out_step_k2), .out_ra(out_ra2), .out_rb(out_rb2),
    .out_rc(out_rc2), .out_b_sel(out_b_sel2), .out_first(out_first2), .out_last(out_last2),
    .busy(busy2)
  );

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  fs, fd;
    logic [0:0]  m;
    logic [1:0]  n, k;
    logic [4:0]  ra, rb, rc;
    logic [0:0]  bsel;
    logic        first, last;
  } uop_t;

  uop_t q[$];
  uop_t prev_obs;
  bit   prev_stall, accepted;
  int   checks = 0, failures = 0, hs_cnt = 0;

  // Default geometry: M_ST=2, N_ST=4, K_ST=4, A_SUB=1, B_SUB=2, RB=10, RC=24.
  function automatic uop_t model(int i, bit kin, logic [15:0] tag, logic [3:0] fs, logic [3:0] fd);
    uop_t u;
    int m, n, k;
    if (kin) begin
      k = i % 4; n = (i / 4) % 4;
    end else begin
      n = i % 4; k = (i / 4) % 4;
    end
    m = i / 16;
    u.tag = tag; u.fs = fs; u.fd = fd;
    u.m = 1'(m); u.n = 2'(n); u.k = 2'(k);
    u.ra = 5'(m * 4 + k);
    u.rb = 5'(10 + (n * 4 + k) / 2);
    u.bsel = 1'((n * 4 + k) % 2);
    u.rc = 5'(24 + m * 4 + n);
    u.first = (k == 0);
    u.last = (i == 31);
    return u;
  endfunction

  function automatic uop_t cur();
    uop_t u;
    u = {out_tag, out_fmt_s, out_fmt_d, out_step_m, out_step_n, out_step_k,
         out_ra, out_rb, out_rc, out_b_sel, out_first, out_last};
    return u;
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock of monitoring: inputs are already driven; checks happen before the edge.
  task automatic cyc();
    uop_t obs;
    bit   exp_ready, hs;
    #1;
    obs       = cur();
    exp_ready = !flush && (q.size() == 0 || (out_ready && q.size() == 1));
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    if (prev_stall) chk("stall_stable", 64'(obs), 64'(prev_obs));
    hs = out_valid && out_ready && !flush;
    if (hs) begin
      if (q.size() == 0) chk("unexpected_uop", 64'(obs), 64'(0));
      else chk("uop", 64'(obs), 64'(q.pop_front()));
      hs_cnt++;
    end
    prev_stall = out_valid && !out_ready && !flush;
    prev_obs   = obs;
    accepted   = in_valid && in_ready;
    if (flush) begin
      q.delete();
      prev_stall = 1'b0;
    end else if (accepted) begin
      for (int i = 0; i < 32; i++) q.push_back(model(i, in_k_inner, in_tag, in_fmt_s, in_fmt_d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [15:0] tag, bit kin);
    in_valid = 1'b1; in_tag = tag; in_k_inner = kin;
    in_fmt_s = tag[3:0]; in_fmt_d = tag[7:4]; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("accept", 64'(accepted), 64'(1));
  endtask

  task automatic drain(input int budget, input bit rnd, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      cycles++;
    end
    out_ready = 1'b1;
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int c, base, n2;
    bit seen_last;
    reset_n = 1'b0; in_valid = 1'b0; in_tag = '0; in_fmt_s = '0; in_fmt_d = '0;
    in_k_inner = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0;
    prev_stall = 1'b0;
    #12;
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_fields", 64'(cur()), 64'(0));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // k innermost, no stalls: 32 uops on consecutive cycles
    issue(16'hA1B2, 1'b1);
    drain(100, 1'b0, c);
    chk("k_inner_cycles", 64'(c), 64'(32));
    cyc();

    // n innermost
    issue(16'h00C3, 1'b0);
    drain(100, 1'b0, c);
    chk("n_inner_cycles", 64'(c), 64'(32));
    cyc();

    // random 50% backpressure
    base = hs_cnt;
    issue(16'h5A5A, 1'b1);
    drain(400, 1'b1, c);
    chk("stall_handshakes", 64'(hs_cnt - base), 64'(32));
    cyc();

    // second instruction held valid during the first: zero-bubble hand-off
    in_valid = 1'b1; in_tag = 16'h1111; in_k_inner = 1'b1; in_fmt_s = 4'h1; in_fmt_d = 4'h2;
    out_ready = 1'b1;
    cyc();
    in_tag = 16'h2222; in_k_inner = 1'b0; in_fmt_s = 4'hE; in_fmt_d = 4'hF;
    c = 0;
    do begin cyc(); c++; end while (!accepted && c < 100);
    in_valid = 1'b0;
    chk("b2b_accept", 64'(accepted), 64'(1));
    chk("b2b_wait", 64'(c), 64'(32));
    drain(100, 1'b0, c);
    cyc();

    // flush at uop 10 with a same-cycle request
    base = hs_cnt;
    issue(16'hF00D, 1'b1);
    c = 0;
    while (hs_cnt - base < 10 && c < 50) begin cyc(); c++; end
    chk("flush_reach", 64'(hs_cnt - base), 64'(10));
    flush = 1'b1; in_valid = 1'b1; in_tag = 16'hBEEF; out_ready = 1'b0;
    cyc();
    chk("flush_no_accept", 64'(accepted), 64'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    issue(16'hBEEF, 1'b1);
    drain(100, 1'b0, c);
    cyc();

    // asynchronous reset at uop 7
    base = hs_cnt;
    issue(16'h7777, 1'b0);
    c = 0;
    while (hs_cnt - base < 7 && c < 50) begin cyc(); c++; end
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_fields", 64'(cur()), 64'(0));
    q.delete(); prev_stall = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h8888, 1'b1);
    drain(100, 1'b0, c);
    chk("post_reset_cycles", 64'(c), 64'(32));
    cyc();

    // 32-thread geometry: count uops and locate the last flag
    in_valid2 = 1'b1;
    #1;
    chk("dut32_ready", 64'(in_ready2), 64'(1));
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n2 = 0; c = 0; seen_last = 1'b0;
    while (!seen_last && c < 100) begin
      if (out_valid2) begin
        if (n2 == 0) begin
          chk("dut32_rb0", 64'(out_rb2), 64'(10));
          chk("dut32_rc0", 64'(out_rc2), 64'(24));
        end
        if (out_last2) begin
          seen_last = 1'b1;
          chk("dut32_last_rc", 64'(out_rc2), 64'(31));
          chk("dut32_last_rb", 64'(out_rb2), 64'(17));
        end
        n2++;
      end
      @(posedge clk); #1;
      c++;
    end
    chk("dut32_count", 64'(n2), 64'(32));
    chk("dut32_idle", 64'(out_valid2), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
